// File: rtl/cla4_block.sv
// cla4_block: 4-bit carry-lookahead adder with registered outputs.
// Per-bit generate/propagate terms feed a two-level lookahead carry network.
// There is no ripple path from C0 to C4.
// Sum, carry-out and group P/G are captured on every rising clock edge.
// The asynchronous reset clears all four outputs immediately.
module cla4_block (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       C0,
   output logic       Carry,
   output logic [3:0] Sum,
   output logic       P,
   output logic       G
);

   // Per-bit generate and propagate terms.
   logic [3:0] g_s;
   logic [3:0] p_s;

   // Lookahead carries into bits 1..3, plus the carry out of bit 3.
   logic       c1_s;
   logic       c2_s;
   logic       c3_s;
   logic       c4_s;

   // Carry into each bit position; bit 0 takes the external carry-in.
   logic [3:0] cin_s;

   // Combinational results that the output registers capture.
   logic [3:0] sum_s;
   logic       grp_p_s;
   logic       grp_g_s;

   // Output registers.
   logic       carry_r;
   logic [3:0] sum_r;
   logic       grp_p_r;
   logic       grp_g_r;

   // Bit-level generate (both operands set) and propagate (exactly one set).
   always_comb begin
      g_s = A & B;
      p_s = A ^ B;
   end

   // Two-level sum-of-products carries. Each carry is flattened so that C0
   // reaches every carry through a single AND-OR level.
   always_comb begin
      c1_s = g_s[0]
           | (p_s[0] & C0);

      c2_s = g_s[1]
           | (p_s[1] & g_s[0])
           | (p_s[1] & p_s[0] & C0);

      c3_s = g_s[2]
           | (p_s[2] & g_s[1])
           | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & C0);

      c4_s = g_s[3]
           | (p_s[3] & g_s[2])
           | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & C0);
   end

   // Group terms depend only on A and B, so a higher-level lookahead stage
   // could use them without waiting for C0.
   always_comb begin
      grp_p_s = p_s[3] & p_s[2] & p_s[1] & p_s[0];

      grp_g_s = g_s[3]
              | (p_s[3] & g_s[2])
              | (p_s[3] & p_s[2] & g_s[1])
              | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
   end

   // Each sum bit is that bit's propagate term XORed with its incoming carry.
   always_comb begin
      cin_s = {c3_s, c2_s, c1_s, C0};
      sum_s = p_s ^ cin_s;
   end

   // Capture the results every cycle; reset clears them without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_r <= 1'b0;
         sum_r   <= 4'b0000;
         grp_p_r <= 1'b0;
         grp_g_r <= 1'b0;
      end else begin
         carry_r <= c4_s;
         sum_r   <= sum_s;
         grp_p_r <= grp_p_s;
         grp_g_r <= grp_g_s;
      end
   end

   assign Carry = carry_r;
   assign Sum   = sum_r;
   assign P     = grp_p_r;
   assign G     = grp_g_r;

endmodule

// File: tb/tb_cla4_block.sv
// tb_cla4_block: self-checking bench for cla4_block.
// Expected values come from plain 5-bit arithmetic on A, B and C0.
module tb_cla4_block;

   logic       clk;
   logic       rst;
   logic [3:0] A;
   logic [3:0] B;
   logic       C0;
   logic       Carry;
   logic [3:0] Sum;
   logic       P;
   logic       G;

   int n_tests;
   int n_fail;

   cla4_block dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .C0    (C0),
      .Carry (Carry),
      .Sum   (Sum),
      .P     (P),
      .G     (G)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model. The result is packed as {Carry, Sum[3:0], P, G}.
   // G is set when A+B alone overflows 4 bits.
   // P is set when A and B differ in every bit, that is A+B == 15 with no bit generating a carry.
   function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b, input logic c);
      int total;
      logic pp, gg;
      total = int'(a) + int'(b) + int'(c);
      gg = ((int'(a) + int'(b)) > 15);
      pp = ((a ^ b) == 4'b1111);
      return {total[4:0], pp, gg};
   endfunction

   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c);
      A = a;
      B = b;
      C0 = c;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      apply(4'hF, 4'hF, 1'b1);
      @(posedge clk);
      #1;
      n_tests++;
      if ({Carry, Sum, P, G} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_hold actual=%b required=%b", {Carry, Sum, P, G}, 7'b0);
      end
      // Release reset away from the clock edge. The first edge after release loads the current inputs.
      #2 rst = 1'b0;
      apply(4'b1010, 4'b0011, 1'b0);
      @(posedge clk);
      #1;
      n_tests++;
      if ({Carry, Sum, P, G} !== model(4'b1010, 4'b0011, 1'b0)) begin
         n_fail++;
         $display("FAIL reset_first_load actual=%b required=%b", {Carry, Sum, P, G}, model(4'b1010, 4'b0011, 1'b0));
      end
   endtask

   task automatic test_directed;
      logic [3:0] ta[5] = '{4'b1010, 4'b1110, 4'b1110, 4'b0000, 4'b0101};
      logic [3:0] tb_[5] = '{4'b0011, 4'b1000, 4'b1001, 4'b1111, 4'b1000};
      logic       tc[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      // Hand-computed expected values, packed as {Carry, Sum, P, G}.
      logic [6:0] te[5] = '{7'b0_1101_0_0, 7'b1_0110_0_1, 7'b1_1000_0_1,
                            7'b1_0000_1_0, 7'b0_1110_0_0};
      for (int i = 0; i < 5; i++) begin
         apply(ta[i], tb_[i], tc[i]);
         @(posedge clk);
         #1;
         n_tests++;
         if ({Carry, Sum, P, G} !== te[i]) begin
            n_fail++;
            $display("FAIL directed_%0d actual=%b required=%b", i, {Carry, Sum, P, G}, te[i]);
         end
      end
   endtask

   // Every vector is applied on consecutive cycles with no idle cycles in between.
   task automatic test_exhaustive;
      int bad;
      logic [6:0] exp_v;
      bad = 0;
      for (int v = 0; v < 512; v++) begin
         logic [8:0] vv;
         vv = v[8:0];
         apply(vv[3:0], vv[7:4], vv[8]);
         exp_v = model(vv[3:0], vv[7:4], vv[8]);
         @(posedge clk);
         #1;
         n_tests++;
         if ({Carry, Sum} !== exp_v[6:2]) begin
            n_fail++;
            bad++;
            if (bad < 10)
               $display("FAIL exhaustive_sum A=%h B=%h C0=%b actual=%b required=%b",
                        vv[3:0], vv[7:4], vv[8], {Carry, Sum}, exp_v[6:2]);
         end
         n_tests++;
         if (Carry !== (G | (P & vv[8]))) begin
            n_fail++;
            bad++;
            if (bad < 10)
               $display("FAIL exhaustive_group A=%h B=%h C0=%b actual_carry=%b required=%b",
                        vv[3:0], vv[7:4], vv[8], Carry, G | (P & vv[8]));
         end
         n_tests++;
         if ({P, G} !== exp_v[1:0]) begin
            n_fail++;
            bad++;
            if (bad < 10)
               $display("FAIL exhaustive_pg A=%h B=%h C0=%b actual=%b required=%b",
                        vv[3:0], vv[7:4], vv[8], {P, G}, exp_v[1:0]);
         end
      end
   endtask

   // Random vectors, with an input change between edges that must not reach the outputs.
   task automatic test_random;
      logic [3:0] a, b;
      logic c;
      logic [6:0] exp_v;
      for (int i = 0; i < 200; i++) begin
         a = 4'($urandom_range(15, 0));
         b = 4'($urandom_range(15, 0));
         c = 1'($urandom_range(1, 0));
         apply(a, b, c);
         exp_v = model(a, b, c);
         @(posedge clk);
         #1;
         n_tests++;
         if ({Carry, Sum, P, G} !== exp_v) begin
            n_fail++;
            $display("FAIL random_%0d actual=%b required=%b", i, {Carry, Sum, P, G}, exp_v);
         end
         apply(~a, b + 4'd3, ~c);
         #2;
         n_tests++;
         if ({Carry, Sum, P, G} !== exp_v) begin
            n_fail++;
            $display("FAIL midcycle_hold_%0d actual=%b required=%b", i, {Carry, Sum, P, G}, exp_v);
         end
      end
   endtask

   // Reset asserted mid-cycle clears nonzero outputs at once and drops the pending result.
   task automatic test_reset_midop;
      apply(4'b0000, 4'b1111, 1'b1);
      @(posedge clk);
      #1;
      n_tests++;
      if ({Carry, Sum, P, G} !== model(4'b0000, 4'b1111, 1'b1)) begin
         n_fail++;
         $display("FAIL pre_reset_load actual=%b required=%b", {Carry, Sum, P, G}, model(4'b0000, 4'b1111, 1'b1));
      end
      apply(4'b1110, 4'b1001, 1'b1);
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if ({Carry, Sum, P, G} !== 7'b0) begin
         n_fail++;
         $display("FAIL async_reset actual=%b required=%b", {Carry, Sum, P, G}, 7'b0);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if ({Carry, Sum, P, G} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_discard actual=%b required=%b", {Carry, Sum, P, G}, 7'b0);
      end
      #2 rst = 1'b0;
      apply(4'b0101, 4'b1100, 1'b0);
      @(posedge clk);
      #1;
      n_tests++;
      if ({Carry, Sum, P, G} !== model(4'b0101, 4'b1100, 1'b0)) begin
         n_fail++;
         $display("FAIL post_reset_load actual=%b required=%b", {Carry, Sum, P, G}, model(4'b0101, 4'b1100, 1'b0));
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      rst = 1'b1;
      A = 4'b0000;
      B = 4'b0000;
      C0 = 1'b0;
      #1;
      test_reset;
      test_directed;
      test_exhaustive;
      test_random;
      test_reset_midop;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cla4_block.md
CLA4_BLOCK -- requirements
Module: cla4_block

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 4 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 A  input  4  addend A, unsigned, bit 0 = LSB.
REQ-005 B  input  4  addend B, unsigned, bit 0 = LSB.
REQ-006 C0  input  1  carry-in to bit 0.
REQ-007 Carry  output  1  registered carry-out of bit 3 (C4).
REQ-008 Sum  output  4  registered sum bits.
REQ-009 P  output  1  registered group propagate.
REQ-010 G  output  1  registered group generate.
REQ-011 The port order SHALL be clk, rst, A, B, C0, Carry, Sum, P, G.

Function
REQ-012 The block SHALL compute the per-bit terms combinationally as g[i] = A[i] AND B[i] and p[i] = A[i] XOR B[i], for i = 0..3.
REQ-013 The internal carries SHALL use two-level lookahead, with no ripple chain:
- c1 = g0 | p0·C0
- c2 = g1 | p1·g0 | p1·p0·C0
- c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·C0
- c4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·C0
REQ-014 Each sum bit SHALL be Sum[i] = p[i] XOR c[i], with c0 = C0.
REQ-015 The group terms SHALL be P = p3·p2·p1·p0 and G = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0.
REQ-016 Carry SHALL equal c4, which is identical to G | (P·C0).
REQ-017 The result {Carry, Sum} SHALL equal A + B + C0 as a 5-bit unsigned value for all 512 input combinations.
REQ-018 On each rising clk edge with rst low, Carry, Sum, P and G SHALL register the combinational results of the A, B and C0 values present at that edge.
REQ-019 Latency SHALL be 1 cycle: inputs stable before edge N appear at the outputs after edge N.
REQ-020 There SHALL be no handshake; a new operation is accepted on every cycle, and output values hold between edges.
REQ-021 Input changes between clock edges SHALL NOT affect the outputs until the next rising edge.
REQ-022 P and G SHALL reflect only A and B and SHALL be independent of C0.

Reset
REQ-023 While rst is high, Carry, Sum, P and G SHALL be 0 immediately, without waiting for a clock edge.
REQ-024 When rst asserts mid-operation, it SHALL discard the pending result.
REQ-025 The first rising edge with rst low SHALL load the result of the current inputs.
REQ-026 The block SHALL hold no state other than the output registers.

Verification
REQ-027 Assert rst while outputs are nonzero -> Carry=0, Sum=0000, P=0, G=0 before the next edge.
REQ-028 A=1010, B=0011, C0=0, one edge -> Sum=1101, Carry=0, P=0, G=0.
REQ-029 A=1110, B=1000, C0=0 -> Sum=0110, Carry=1, P=0, G=1.
REQ-030 A=1110, B=1001, C0=1 -> Sum=1000, Carry=1, P=0, G=1.
REQ-031 A=0000, B=1111, C0=1 -> Sum=0000, Carry=1, P=1, G=0 (full propagate path).
REQ-032 A=0101, B=1000, C0=1 -> Sum=1110, Carry=0, P=0, G=0.
REQ-033 An exhaustive sweep of A, B and C0 -> {Carry, Sum} equals A+B+C0 and Carry equals G|(P·C0), one cycle after each vector is applied.
